// File: rtl/serial_pkg.sv
// Shared definitions for the framed serial transmitter and its matching receiver.
package serial_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } ser_state_e;

    localparam logic LINE_IDLE   = 1'b1;
    localparam logic START_LEVEL = 1'b0;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        if (n > 1) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/piso_frame_tx_bit_tick_gen.sv
// Clock divider: counts 0..CLKS_PER_BIT-1 and flags the terminal count as a bit tick.
module bit_tick_gen
    import serial_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int            CW   = cnt_width(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;

    // Free-running divider, realigned to zero whenever a new frame is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (restart || (cnt_q == LAST)) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/piso_frame_tx.sv
// Framed parallel-in/serial-out transmitter: start bit, WIDTH data bits, STOP_BITS stop bits,
// each held CLKS_PER_BIT clocks, with true and complementary line outputs from one register stage.
module piso_frame_tx
    import serial_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int STOP_BITS    = 1,
    parameter int LSB_FIRST    = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sout,
    output logic             sout_n,
    output logic             busy,
    output logic             frame_done
);

    localparam int            BW        = cnt_width((WIDTH > STOP_BITS) ? WIDTH : STOP_BITS);
    localparam logic [BW-1:0] LAST_DATA = BW'(WIDTH - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

    if ((STOP_BITS < 1) || (STOP_BITS > 2)) begin : g_bad_stop_bits
        $error("piso_frame_tx: STOP_BITS must be 1 or 2");
    end

    ser_state_e       state_q;
    logic [BW-1:0]    bit_cnt_q;
    logic [WIDTH-1:0] sreg_q;
    logic [WIDTH-1:0] sreg_shift_s;
    logic             sout_q;
    logic             sout_n_q;
    logic             ready_q;
    logic             busy_q;
    logic             done_q;
    logic             line_d;
    logic             accept_s;
    logic             tick_s;

    // The bit that goes on the line next is always at the head end of the shift register.
    function automatic logic head_bit(input logic [WIDTH-1:0] v);
        if (LSB_FIRST != 0) begin
            return v[0];
        end else begin
            return v[WIDTH-1];
        end
    endfunction

    assign accept_s = din_valid && ready_q;

    bit_tick_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tick (
        .clk    (clk),
        .rst    (rst),
        .restart(accept_s),
        .tick   (tick_s)
    );

    // Shift register contents after dropping the bit currently on the line.
    always_comb begin
        if (LSB_FIRST != 0) begin
            sreg_shift_s = sreg_q >> 1'b1;
        end else begin
            sreg_shift_s = sreg_q << 1'b1;
        end
    end

    // Next line level; sout and sout_n are both registered from this single value.
    always_comb begin
        line_d = sout_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    line_d = START_LEVEL;
                end else begin
                    line_d = LINE_IDLE;
                end
            end
            START: begin
                if (tick_s) begin
                    line_d = head_bit(sreg_q);
                end else begin
                    line_d = sout_q;
                end
            end
            DATA: begin
                if (tick_s && (bit_cnt_q == LAST_DATA)) begin
                    line_d = LINE_IDLE;
                end else if (tick_s) begin
                    line_d = head_bit(sreg_shift_s);
                end else begin
                    line_d = sout_q;
                end
            end
            STOP:    line_d = LINE_IDLE;
            default: line_d = LINE_IDLE;
        endcase
    end

    // Frame sequencer with registered handshake, status and line outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            sreg_q    <= '0;
            sout_q    <= LINE_IDLE;
            sout_n_q  <= ~LINE_IDLE;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            sout_q   <= line_d;
            sout_n_q <= ~line_d;
            done_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept_s) begin
                        state_q   <= START;
                        sreg_q    <= din;
                        bit_cnt_q <= '0;
                        ready_q   <= 1'b0;
                        busy_q    <= 1'b1;
                    end
                end
                START: begin
                    if (tick_s) begin
                        state_q <= DATA;
                    end
                end
                DATA: begin
                    if (tick_s) begin
                        if (bit_cnt_q == LAST_DATA) begin
                            state_q   <= STOP;
                            bit_cnt_q <= '0;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + BW'(1);
                            sreg_q    <= sreg_shift_s;
                        end
                    end
                end
                STOP: begin
                    if (tick_s) begin
                        if (bit_cnt_q == LAST_STOP) begin
                            state_q   <= IDLE;
                            bit_cnt_q <= '0;
                            ready_q   <= 1'b1;
                            busy_q    <= 1'b0;
                            done_q    <= 1'b1;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + BW'(1);
                        end
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    bit_cnt_q <= '0;
                    ready_q   <= 1'b1;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    assign din_ready  = ready_q;
    assign busy       = busy_q;
    assign frame_done = done_q;
    assign sout       = sout_q;
    assign sout_n     = sout_n_q;

endmodule

// File: tb/tb_piso_frame_tx.sv
// Bench for piso_frame_tx: two configurations checked cycle by cycle against a frame-level model.
module tb_piso_frame_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: C=4, one stop bit, LSB first. Instance B: C=1, two stop bits, MSB first.
    logic       a_rst, a_valid, a_ready, a_sout, a_sout_n, a_busy, a_done;
    logic [7:0] a_din;
    logic       b_rst, b_valid, b_ready, b_sout, b_sout_n, b_busy, b_done;
    logic [7:0] b_din;

    int total = 0;
    int bad   = 0;

    piso_frame_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .STOP_BITS(1), .LSB_FIRST(1)) dut_a (
        .clk(clk), .rst(a_rst), .din(a_din), .din_valid(a_valid), .din_ready(a_ready),
        .sout(a_sout), .sout_n(a_sout_n), .busy(a_busy), .frame_done(a_done)
    );

    piso_frame_tx #(.WIDTH(8), .CLKS_PER_BIT(1), .STOP_BITS(2), .LSB_FIRST(0)) dut_b (
        .clk(clk), .rst(b_rst), .din(b_din), .din_valid(b_valid), .din_ready(b_ready),
        .sout(b_sout), .sout_n(b_sout_n), .busy(b_busy), .frame_done(b_done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int cpb(input int d);
        return (d == 0) ? 4 : 1;
    endfunction

    function automatic int stopb(input int d);
        return (d == 0) ? 1 : 2;
    endfunction

    // Expected line level c cycles after the accept edge: frame bit index = c / C.
    function automatic logic exp_line(input int d, input logic [7:0] w, input int c);
        int idx;
        idx = c / cpb(d);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return (d == 0) ? w[idx-1] : w[8-idx];
        return 1'b1;
    endfunction

    // Observed outputs packed as {din_ready, sout, sout_n, busy, frame_done}.
    function automatic logic [4:0] outs(input int d);
        if (d == 0) return {a_ready, a_sout, a_sout_n, a_busy, a_done};
        else return {b_ready, b_sout, b_sout_n, b_busy, b_done};
    endfunction

    task automatic drive(input int d, input logic v, input logic [7:0] w);
        if (d == 0) begin
            a_valid = v;
            a_din   = w;
        end else begin
            b_valid = v;
            b_din   = w;
        end
    endtask

    // Called at a negedge; sends w and returns at the negedge of the frame_done cycle.
    task automatic send(input int d, input logic [7:0] w, input bit hold, input string tag);
        int         len;
        int         waited;
        logic [4:0] o;
        logic       e;
        len    = (9 + stopb(d)) * cpb(d);
        waited = 0;
        o      = outs(d);
        while (!o[4] && waited < 200) begin
            @(negedge clk);
            waited++;
            o = outs(d);
        end
        check({tag, "/ready"}, o[4], 1'b1);
        drive(d, 1'b1, w);
        @(posedge clk);
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            drive(d, hold, 8'($urandom));
            e = exp_line(d, w, i);
            check($sformatf("%s/c%0d", tag, i), outs(d), {1'b0, e, ~e, 1'b1, 1'b0});
        end
        @(negedge clk);
        check({tag, "/done"}, outs(d), 5'b11001);
    endtask

    task automatic idle_cycles(input int d, input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            drive(d, 1'b0, 8'($urandom));
            check($sformatf("%s/i%0d", tag, i), outs(d), 5'b11000);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        a_rst = 1'b0; b_rst = 1'b0;
        drive(0, 1'b0, 8'h00);
        drive(1, 1'b0, 8'h00);
        #1;
        a_rst = 1'b1; b_rst = 1'b1;

        // Reset held three cycles, then idle stall of 20 cycles on both instances.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("rst_a/%0d", i), outs(0), 5'b11000);
            check($sformatf("rst_b/%0d", i), outs(1), 5'b11000);
        end
        a_rst = 1'b0; b_rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check($sformatf("stall_a/%0d", i), outs(0), 5'b11000);
            check($sformatf("stall_b/%0d", i), outs(1), 5'b11000);
        end

        send(0, 8'h01, 1'b0, "w01");
        send(0, 8'hA5, 1'b0, "wA5");
        send(1, 8'h81, 1'b0, "w81");

        // Back-to-back: valid held through the first frame, second word in the done cycle.
        send(0, 8'h00, 1'b1, "b2b0");
        send(0, 8'hFF, 1'b0, "b2b1");
        idle_cycles(0, 12, "b2b_after");
        send(1, 8'h00, 1'b1, "b2b0b");
        send(1, 8'hFF, 1'b0, "b2b1b");
        idle_cycles(1, 5, "b2b_after_b");

        // Asynchronous reset between edges during data bit 3 of 8'h3C.
        drive(0, 1'b1, 8'h3C);
        @(posedge clk);
        @(negedge clk);
        drive(0, 1'b0, 8'($urandom));
        repeat (17) @(negedge clk);
        check("midrst/pre", outs(0), {1'b0, 1'b1, 1'b0, 1'b1, 1'b0});
        #1 a_rst = 1'b1;
        #1 check("midrst/async", outs(0), 5'b11000);
        @(negedge clk);
        check("midrst/held", outs(0), 5'b11000);
        a_rst = 1'b0;
        idle_cycles(0, 40, "midrst_after");
        send(0, 8'h5A, 1'b0, "w5A");

        // Randomized frames on either instance with random idle gaps (gap 0 = back-to-back).
        for (int n = 0; n < 16; n++) begin
            int         d;
            int         gap;
            logic [7:0] w;
            d   = int'($urandom_range(0, 1));
            gap = int'($urandom_range(0, 3));
            w   = 8'($urandom);
            if (gap > 0) idle_cycles(d, gap, $sformatf("rgap%0d", n));
            send(d, w, 1'b0, $sformatf("rnd%0d", n));
        end
        idle_cycles(0, 2, "end_a");
        idle_cycles(1, 2, "end_b");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/piso_frame_tx.md
Name: piso_frame_tx

Overview:
- Framed parallel-in/serial-out transmitter.
- Accepts one WIDTH-bit word per valid/ready handshake.
- Shifts the word onto a single line as: start bit (0), data bits, stop bit(s) (1). Each bit is held CLKS_PER_BIT clocks.
- Drives a true output and a complementary output from the same register stage. It is the sending end for the team's flop-based serial capture chains.

Parameters:
- WIDTH, 8, data word width (>=1).
- CLKS_PER_BIT, 4, clocks each serial bit is held (>=1; 1 gives one bit per clock).
- STOP_BITS, 1, number of stop bits (1 or 2).
- LSB_FIRST, 1, 1 = din[0] sent first; 0 = din[WIDTH-1] sent first.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- din  input  WIDTH  parallel word to send.
- din_valid  input  1  din holds a word to send.
- din_ready  output  1  block is idle and can accept a word.
- sout  output  1  serial line; idles at 1.
- sout_n  output  1  always the complement of sout (registered, never skewed).
- busy  output  1  a frame is in progress.
- frame_done  output  1  one-cycle pulse when a frame completes.

Behaviour:
- Reset (asynchronous, active-high; takes effect immediately regardless of clk):
  - sout=1, sout_n=0, din_ready=1, busy=0, frame_done=0.
  - State IDLE; bit counter and clock-divider counter cleared.
- All outputs are registered. din_ready=(state==IDLE); busy=~din_ready.
- Accept: a word is captured into the shift register on the rising edge where din_valid && din_ready (call this edge T0).
  - din is ignored at all other times.
  - din_valid held high while busy has no effect; the word is not queued.
- States: IDLE -> START -> DATA -> STOP -> IDLE.
  - START: sout=0, visible from T0 for C cycles (C=CLKS_PER_BIT).
  - DATA: bit k (k=0..WIDTH-1, ordered per LSB_FIRST) visible from T0+(1+k)*C for C cycles.
  - STOP: sout=1 from T0+(1+WIDTH)*C for STOP_BITS*C cycles.
  - Return to IDLE on edge T0+(1+WIDTH+STOP_BITS)*C.
    - frame_done=1 and din_ready=1 for exactly that one cycle.
    - sout stays 1.
- Frame length: (1+WIDTH+STOP_BITS)*C cycles, plus at least one idle cycle between frames.
  - A word presented during the frame_done cycle is accepted on that cycle's closing edge.
  - Its start bit follows immediately (back-to-back minimum spacing).
- Clock divider: counts 0..C-1 and generates a bit tick on terminal count. It restarts at 0 on accept. With C=1 a tick fires every cycle.
- Bit counter: counts data bits 0..WIDTH-1, then stop bits 0..STOP_BITS-1. No wrap beyond these; it is cleared on entry to START.
- Shift register: shifts by one only on the bit tick in DATA; its contents are don't-care in other states.
- sout_n==~sout in every cycle, including during and immediately after reset.
- Reset mid-frame aborts the frame:
  - Line returns to 1 at once.
  - No frame_done pulse.
  - din_ready=1 on the first edge after rst deasserts.
- Illegal STOP_BITS values are rejected at elaboration (generate-time error).

Decomposition:
- Shared package serial_pkg:
  - Typedef of the state enum (IDLE, START, DATA, STOP).
  - Constants LINE_IDLE=1'b1, START_LEVEL=1'b0.
  - Function computing counter width from CLKS_PER_BIT.
  - The same package is reused by the matching receiver.
- One sub-module: bit_tick_gen.
  - Parameterised by CLKS_PER_BIT; inputs clk, rst, restart; output tick.
  - It is the only counter shared with the receiver.

Test Plan:
- Reset: WIDTH=8, C=4, STOP_BITS=1; hold rst 3 cycles -> sout=1, sout_n=0, din_ready=1, busy=0, frame_done=0 throughout and after release.
- Single frame, LSB first: din=8'hA5 with din_valid for one cycle.
  - sout holds each of 0,1,0,1,0,0,1,0,1,1 for 4 cycles.
  - busy=1 for 40 cycles.
  - frame_done pulses once on cycle 40; sout_n is the mirror every cycle.
- MSB first, C=1, STOP_BITS=2: din=8'h81 -> sout = 0,1,0,0,0,0,0,0,1,1,1 on consecutive cycles; frame_done after 11 cycles.
- Back-to-back: din_valid held high with din=8'h00, then 8'hFF presented in the frame_done cycle.
  - The second start bit begins on the cycle right after frame_done.
  - Only 2 frames are sent; din changes during busy do not alter the frame in flight.
- Reset mid-frame: assert rst asynchronously (between edges) during data bit 3 of 8'h3C.
  - sout goes to 1 before the next clk edge.
  - No frame_done pulse.
  - The next word 8'h5A is sent correctly.
- Stall: din_valid=0 for 20 cycles after reset -> line stays 1 and din_ready stays 1; then din=8'h01, C=4 -> first data bit 1 appears at accept+4 cycles.
